vedic_mul_arbiter: RTL and testbench
====================================

Name: vedic_mul_arbiter

Overview:
Round-robin arbiter that time-shares one pipelined 8x8 Vedic multiplier among NREQ requesters in the matrix multiplier.
- Accepts operand pairs over valid/ready.
- Issues at most one product per cycle to the multiplier.
- Tracks in-flight operations with a tag pipeline matched to the multiplier latency.
- Returns each 16-bit product to its originating requester over valid/ready.

Parameters:
NREQ, 4, number of requesters (2..8)
MUL_LAT, 3, cycles from mul_a/mul_b update edge to the edge at which mul_result holds that product
IDX_W, 2, requester index width, must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operand pair valid
req_a  input  NREQ*8  operand a, requester i at [8i+7:8i]
req_b  input  NREQ*8  operand b, requester i at [8i+7:8i]
req_ready  output  NREQ  one-hot grant; accept when req_valid[i]&req_ready[i]
mul_a  output  8  registered operand a to multiplier
mul_b  output  8  registered operand b to multiplier
mul_result  input  16  multiplier product
rsp_valid  output  NREQ  per-requester product valid
rsp_data  output  NREQ*16  product, requester i at [16i+15:16i]
rsp_ready  input  NREQ  per-requester product consume

Behaviour:
- Reset (async assert, sync release): req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_data=0, tag pipeline empty, busy flags clear, RR pointer=0.
- Reset mid-operation: all in-flight tags and pending responses are discarded; no rsp_valid after release until new requests are accepted.
- Eligibility: requester i is eligible when req_valid[i]=1 and busy[i]=0. busy[i] sets on accept and clears on rsp handshake, so each requester has at most one outstanding operation.
- Grant: req_ready is combinational, one-hot or zero. It selects the first eligible index at or after ptr, wrapping modulo NREQ.
- On accept of index g at edge T:
  - ptr <= (g+1) mod NREQ; ptr holds when there is no accept.
  - mul_a <= req_a[g], mul_b <= req_b[g].
  - Tag stage 0 <= {valid=1, idx=g}.
- Idle cycle (no accept): mul_a/mul_b hold their previous value; tag stage 0 valid=0.
- Tag pipeline: MUL_LAT stages, shifting every cycle unconditionally. The multiplier cannot stall, so the arbiter never back-pressures it.
- Capture: at edge T+MUL_LAT, the tag at the final stage with valid=1 and idx=k gives rsp_data[k] <= mul_result and rsp_valid[k] <= 1.
- Latency: accept to rsp_valid high is MUL_LAT+1 cycles, with throughput of one product per cycle.
- rsp_valid[k] clears, and busy[k] clears, on the edge where rsp_valid[k]&rsp_ready[k]=1. rsp_data[k] holds until it is overwritten.
- Simultaneous consume and re-request by the same k: busy clears only at the consume edge, so the new grant comes no earlier than the next cycle.
- Width: the product is 16-bit unsigned with no truncation; mul_result is passed through unmodified.
- Simultaneous capture for k and consume for another index j are independent.

Optional Feature:
Macro ARB_STATS_EN.
- Defined: adds output issue_cnt (32-bit), which increments on every accept, resets to 0, and wraps at 2^32-1 to 0. Also adds output stall_cnt (32-bit), which increments each cycle where any req_valid=1 but no accept occurs, with the same reset and wrap behaviour.
- Undefined: neither port nor its counter logic exists; all other behaviour is identical.

Test Plan:
- Single request, requester 0 a=8'd13 b=8'd11, rsp_ready=1 -> rsp_valid[0] high exactly MUL_LAT+1 cycles after accept with rsp_data[0]=16'd143, and req_ready[0] low until consume.
- All four requesters valid with ptr=0, a=255 b=255 each -> grants in order 0,1,2,3 on consecutive cycles, each rsp_data=16'd65025, responses arriving on 4 consecutive cycles.
- Fairness: requesters 1 and 3 continuously re-requesting with rsp_ready=1 -> grants alternate 1,3,1,3 with no starvation; ptr wrap 3->0 is exercised.
- Back-pressure: requester 2 with rsp_ready[2]=0 for 10 cycles -> rsp_valid[2] holds and rsp_data[2] is stable, with no re-grant to 2 while other requesters continue at full rate.
- Reset mid-flight: assert rst_n=0 with 3 tags in flight -> all outputs go to 0 immediately, and after release no spurious rsp_valid appears for MUL_LAT+2 cycles.
- ARB_STATS_EN build: 5 accepts plus 3 cycles where valid is set but no requester is eligible -> issue_cnt=5, stall_cnt=3.

Source files
------------

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among NREQ requesters.
// Optional statistics counters (issue_cnt, stall_cnt) when ARB_STATS_EN is defined.
module vedic_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 3,
    parameter int IDX_W   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_a,
    input  logic [NREQ*8-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    input  logic [15:0]          mul_result,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [NREQ*16-1:0]   rsp_data,
    input  logic [NREQ-1:0]      rsp_ready
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]          issue_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    localparam logic [IDX_W:0]   NREQ_W = (IDX_W+1)'(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_idx;
    logic               accept;
    logic [NREQ-1:0]    eligible;
    logic [2*NREQ-1:0]  elig_rot;
    logic [NREQ-1:0]    busy_q, busy_d;
    logic [7:0]         mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NREQ*16-1:0] rsp_data_q, rsp_data_d;
    tag_t               tag_q [MUL_LAT];
    tag_t               tag_tail;

    assign eligible = req_valid & ~busy_q;
    // Rotating by ptr turns "first eligible at or after ptr" into a plain
    // lowest-set-bit search over the doubled vector.
    assign elig_rot = {eligible, eligible} >> ptr_q;

    always_comb begin : grant_search
        logic [IDX_W:0] sum;
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        accept    = 1'b0;
        grant_idx = '0;
        sum       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!accept && elig_rot[i]) begin
                accept = 1'b1;
                sum    = {1'b0, ptr_q} + (IDX_W+1)'(i);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                grant_idx = sum[IDX_W-1:0];
            end
        end
    end

    // Ready is held low while reset is asserted so no accept can be seen.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && accept && (grant_idx == IDX_W'(i));
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (accept) begin
            ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
            for (int i = 0; i < NREQ; i++) begin
                if (grant_idx == IDX_W'(i)) begin
                    mul_a_d = req_a[8*i +: 8];
                    mul_b_d = req_b[8*i +: 8];
                end
            end
        end
    end

    assign tag_tail = tag_q[MUL_LAT-1];

    // Consume, capture and new-grant are evaluated per requester; capture and
    // consume for different indices never interact.
    always_comb begin
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        for (int k = 0; k < NREQ; k++) begin
            if (rsp_valid_q[k] && rsp_ready[k]) begin
                rsp_valid_d[k] = 1'b0;
                busy_d[k]      = 1'b0;
            end
            if (tag_tail.vld && (tag_tail.idx == IDX_W'(k))) begin
                rsp_valid_d[k]        = 1'b1;
                rsp_data_d[16*k +: 16] = mul_result;
            end
            if (accept && (grant_idx == IDX_W'(k))) begin
                busy_d[k] = 1'b1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            // NOTE: the tag stages are reset because their valid bits are
            // control state; a stale tag would raise a spurious response.
            for (int s = 0; s < MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tag_q[0]    <= '{vld: accept, idx: grant_idx};
            for (int s = 1; s < MUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef ARB_STATS_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (accept) begin
                issue_cnt_q <= issue_cnt_q + 32'd1;
            end else if (|req_valid) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Self-checking bench for vedic_mul_arbiter: directed scenarios plus random traffic
// against a transaction-level model. Define ARB_STATS_EN to also check the counters.
module tb_vedic_mul_arbiter;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 3;
    localparam int IDX_W   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*8-1:0]    req_a, req_b;
    logic [NREQ-1:0]      req_ready;
    logic [7:0]           mul_a, mul_b;
    logic [15:0]          mul_result;
    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ*16-1:0]   rsp_data;
    logic [NREQ-1:0]      rsp_ready;
`ifdef ARB_STATS_EN
    logic [31:0]          issue_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    vedic_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_result (mul_result),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_ready  (rsp_ready)
`ifdef ARB_STATS_EN
        ,
        .issue_cnt  (issue_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // Environment multiplier: product of the operands registered at edge T is
    // presented on mul_result so that it is sampled at edge T+MUL_LAT.
    logic [15:0] mpipe [MUL_LAT-1];
    always_ff @(posedge clk) begin
        mpipe[0] <= 16'(mul_a) * 16'(mul_b);
        for (int s = 1; s < MUL_LAT-1; s++) mpipe[s] <= mpipe[s-1];
    end
    assign mul_result = mpipe[MUL_LAT-2];

    // Transaction-level reference model.
    typedef struct {
        int          k;
        logic [15:0] prod;
        int          due;
    } flight_t;

    int              m_ptr;
    bit [NREQ-1:0]   m_busy, m_rv;
    logic [15:0]     m_rd [NREQ];
    logic [7:0]      m_ma, m_mb;
    flight_t         inflight [$];
    logic [31:0]     m_issue, m_stall;
    int              cyc;

    int              checks = 0;
    int              errors = 0;
    logic [NREQ-1:0] last_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_busy = '0; m_rv = '0; m_ma = '0; m_mb = '0;
        for (int k = 0; k < NREQ; k++) m_rd[k] = '0;
        inflight.delete();
        m_issue = '0; m_stall = '0;
    endtask

    function automatic int model_grant();
        for (int off = 0; off < NREQ; off++) begin
            int i = (m_ptr + off) % NREQ;
            if (req_valid[i] && !m_busy[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] r);
        req_valid = v;
        rsp_ready = r;
        for (int i = 0; i < NREQ; i++) begin
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
        end
    endtask

    // One clock: check the grant before the edge, advance the model across
    // the edge, then check every registered output.
    task automatic tick();
        int g;
        flight_t e;
        @(negedge clk);
        g = model_grant();
        check("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        last_rdy = req_ready;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NREQ; k++) begin
            if (m_rv[k] && rsp_ready[k]) begin
                m_rv[k]   = 1'b0;
                m_busy[k] = 1'b0;
            end
        end
        while (inflight.size() > 0 && inflight[0].due == cyc) begin
            e = inflight.pop_front();
            m_rv[e.k] = 1'b1;
            m_rd[e.k] = e.prod;
        end
        if (g >= 0) begin
            m_busy[g] = 1'b1;
            m_ptr     = (g + 1) % NREQ;
            m_ma      = req_a[8*g +: 8];
            m_mb      = req_b[8*g +: 8];
            e.k = g; e.prod = 16'(m_ma) * 16'(m_mb); e.due = cyc + MUL_LAT;
            inflight.push_back(e);
            m_issue++;
        end else if (|req_valid) begin
            m_stall++;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        for (int k = 0; k < NREQ; k++)
            check($sformatf("rsp_data[%0d]", k), 32'(rsp_data[16*k +: 16]), 32'(m_rd[k]));
        check("mul_a", 32'(mul_a), 32'(m_ma));
        check("mul_b", 32'(mul_b), 32'(m_mb));
`ifdef ARB_STATS_EN
        check("issue_cnt", issue_cnt, m_issue);
        check("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, gcount, g2;
        bit seen, have2;
        logic [15:0] held;

        // Reset values, with requests pending so ready must be masked.
        rst_n = 1'b0; req_a = '0; req_b = '0; rsp_ready = '0;
        req_valid = '1;
        model_reset();
        cyc = 0;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < NREQ; k++) check("rst_rsp_data", 32'(rsp_data[16*k +: 16]), 32'd0);
        check("rst_mul_a", 32'(mul_a), 32'd0);
        check("rst_mul_b", 32'(mul_b), 32'd0);
        req_valid = '0;
        @(posedge clk); #3 rst_n = 1'b1;

        // All four requesters at 255*255 from ptr=0.
        req_valid = '1; rsp_ready = '1;
        req_a = {NREQ{8'hFF}}; req_b = {NREQ{8'hFF}};
        for (int i = 0; i < NREQ; i++) begin
            tick();
            check("rr_grant", 32'(last_rdy), 32'(1 << i));
        end
        req_valid = '0;
        check("rr_rsp0", 32'(rsp_valid), 32'd1);
        check("rr_data0", 32'(rsp_data[15:0]), 32'd65025);
        for (int i = 1; i < NREQ; i++) begin
            tick();
            check("rr_rsp", 32'(rsp_valid), 32'(1 << i));
            check("rr_data", 32'(rsp_data[16*i +: 16]), 32'd65025);
        end
        for (int i = 0; i < 3; i++) begin drive('0, '1); tick(); end

        // Single request 13*11 on requester 0; it stays valid while waiting.
        req_valid = 4'b0001; rsp_ready = '1;
        req_a[7:0] = 8'd13; req_b[7:0] = 8'd11;
        tick();
        check("single_grant", 32'(last_rdy), 32'd1);
        n = 1; seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            n++;
            check("single_rdy_low", 32'(last_rdy[0]), 32'd0);
            if (rsp_valid[0]) seen = 1'b1;
        end
        check("single_seen", 32'(seen), 32'd1);
        check("single_latency", 32'(n), 32'(MUL_LAT + 1));
        check("single_data", 32'(rsp_data[15:0]), 32'd143);
        tick();
        check("single_consume_edge", 32'(last_rdy[0]), 32'd0);
        tick();
        check("single_regrant", 32'(last_rdy[0]), 32'd1);
        for (int i = 0; i < 6; i++) begin drive('0, '1); tick(); end

        // Fairness between requesters 1 and 3.
        gcount = 0;
        for (int t = 0; t < 30; t++) begin
            drive(4'b1010, '1);
            tick();
            if (last_rdy != '0) begin
                check("fair_alt", 32'(last_rdy), (gcount % 2 == 0) ? 32'd2 : 32'd8);
                gcount++;
            end
        end
        check("fair_count", 32'(gcount >= 10), 32'd1);
        for (int i = 0; i < 6; i++) begin drive('0, '1); tick(); end

        // Back-pressure on requester 2 while the others keep requesting.
        g2 = 0; have2 = 1'b0; held = '0;
        for (int t = 0; t < 16; t++) begin
            drive('1, 4'b1011);
            tick();
            g2 += int'(last_rdy[2]);
            if (have2) begin
                check("bp_hold_valid", 32'(rsp_valid[2]), 32'd1);
                check("bp_hold_data", 32'(rsp_data[47:32]), 32'(held));
            end else if (rsp_valid[2]) begin
                have2 = 1'b1;
                held  = rsp_data[47:32];
            end
        end
        check("bp_single_grant", 32'(g2), 32'd1);
        check("bp_seen", 32'(have2), 32'd1);
        for (int i = 0; i < 8; i++) begin drive('0, '1); tick(); end

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin drive('1, '1); tick(); end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        for (int k = 0; k < NREQ; k++) check("midrst_rsp_data", 32'(rsp_data[16*k +: 16]), 32'd0);
        check("midrst_mul_a", 32'(mul_a), 32'd0);
        check("midrst_mul_b", 32'(mul_b), 32'd0);
        @(posedge clk); @(posedge clk);
        #3;
        req_valid = '0;
        rst_n = 1'b1;
        for (int t = 0; t < MUL_LAT + 2; t++) begin
            tick();
            check("post_rst_quiet", 32'(rsp_valid), 32'd0);
        end

        // Five accepts and three stalled cycles since the last reset.
        for (int i = 0; i < 7; i++) begin drive('1, '0); tick(); end
        drive('0, 4'b0001); tick();
        drive(4'b0001, '0); tick();
        check("stats_grant0", 32'(last_rdy), 32'd1);
`ifdef ARB_STATS_EN
        check("stats_issue5", issue_cnt, 32'd5);
        check("stats_stall3", stall_cnt, 32'd3);
`endif
        for (int i = 0; i < 10; i++) begin drive('0, '1); tick(); end

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            drive(NREQ'($urandom), NREQ'($urandom));
            tick();
        end
        for (int i = 0; i < 12; i++) begin drive('0, '1); tick(); end
        check("drain_empty", 32'(rsp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
